// File: rtl/rll_key_loader.sv
// Bit-serial unlock-key loader for RLL-locked netlists: shifts in a key plus
// even parity, commits good keys, and locks out after repeated parity failures.
module rll_key_loader #(
   parameter int unsigned KEY_WIDTH = 32,
   parameter int unsigned MAX_TRIES = 4,
   parameter int unsigned LOCK_ONCE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_bit,
   input  logic                 key_valid,
   output logic                 key_ready,
   input  logic                 key_clear,
   output logic [KEY_WIDTH-1:0] key_out,
   output logic                 key_loaded,
   output logic                 key_err,
   output logic                 key_dead
);

   localparam int unsigned CW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
   localparam int unsigned FW = $clog2(MAX_TRIES + 1);

   typedef enum logic [1:0] {S_SHIFT, S_PAR, S_LOCKED, S_DEAD} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [KEY_WIDTH-1:0] shreg;
   logic [FW-1:0]        fail_cnt, fail_inc;
   logic                 xfer, parity_ok, last_bit, clear_ok;

   assign key_ready = (state == S_SHIFT) || (state == S_PAR);
   assign key_dead  = (state == S_DEAD);

   always_comb begin
      xfer      = key_valid & key_ready;
      parity_ok = ~(^shreg ^ key_bit);
      last_bit  = (cnt == CW'(KEY_WIDTH - 1));
      clear_ok  = key_clear && (state != S_DEAD);
      fail_inc  = (fail_cnt == FW'(MAX_TRIES)) ? fail_cnt : fail_cnt + FW'(1);
      state_nxt = state;
      if (clear_ok) begin
         state_nxt = S_SHIFT;
      end else begin
         case (state)
            S_SHIFT: if (xfer && last_bit) state_nxt = S_PAR;
            S_PAR: begin
               if (xfer) begin
                  if (parity_ok)
                     state_nxt = (LOCK_ONCE != 0) ? S_LOCKED : S_SHIFT;
                  else if (fail_inc == FW'(MAX_TRIES))
                     state_nxt = S_DEAD;
                  else
                     state_nxt = S_SHIFT;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_SHIFT;
      else     state <= state_nxt;
   end

   // key_clear outranks a same-cycle transfer, so the accepted bit is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         shreg      <= '0;
         fail_cnt   <= '0;
         key_out    <= '0;
         key_loaded <= 1'b0;
         key_err    <= 1'b0;
      end else if (clear_ok) begin
         cnt        <= '0;
         shreg      <= '0;
         key_out    <= '0;
         key_loaded <= 1'b0;
      end else begin
         case (state)
            S_SHIFT: begin
               if (xfer) begin
                  shreg <= {key_bit, shreg[KEY_WIDTH-1:1]};
                  cnt   <= last_bit ? '0 : cnt + CW'(1);
               end
            end
            S_PAR: begin
               if (xfer) begin
                  shreg <= '0;
                  if (parity_ok) begin
                     key_out    <= shreg;
                     key_loaded <= 1'b1;
                     key_err    <= 1'b0;
                     fail_cnt   <= '0;
                  end else begin
                     key_err  <= 1'b1;
                     fail_cnt <= fail_inc;
                     if (fail_inc == FW'(MAX_TRIES)) begin
                        key_out    <= '0;
                        key_loaded <= 1'b0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: good/bad loads, lockout, clear, recovery,
// stalled transfers and mid-load reset.
module tb_rll_key_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_bit = 1'b0;
   logic        key_valid = 1'b0;
   logic        key_clear = 1'b0;
   logic        key_ready;
   logic [31:0] key_out;
   logic        key_loaded, key_err, key_dead;

   int checks = 0;
   int errors = 0;

   rll_key_loader #(.KEY_WIDTH(32), .MAX_TRIES(4), .LOCK_ONCE(1)) dut (
      .clk(clk), .rst(rst), .key_bit(key_bit), .key_valid(key_valid),
      .key_ready(key_ready), .key_clear(key_clear), .key_out(key_out),
      .key_loaded(key_loaded), .key_err(key_err), .key_dead(key_dead)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      key_valid = 1'b1;
      key_bit   = b;
      @(posedge clk); #1;
      key_valid = 1'b0;
      key_bit   = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] k, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               @(negedge clk);
               key_bit = 1'($urandom_range(0, 1));
            end
         end
         send_bit(k[i]);
      end
   endtask

   task automatic send_key(input logic [31:0] k, input logic p);
      send_bits(k, 32, 1'b0);
      send_bit(p);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      key_clear = 1'b1;
      @(posedge clk); #1;
      key_clear = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_out", key_out, 32'h0);
      chk("rst_loaded", key_loaded, 1'b0);
      chk("rst_err", key_err, 1'b0);
      chk("rst_dead", key_dead, 1'b0);
      chk("rst_ready", key_ready, 1'b1);

      // 1: good load; nothing committed until the parity bit is accepted
      send_bits(32'hA5A50F0F, 32, 1'b0);
      chk("t1_pre_loaded", key_loaded, 1'b0);
      chk("t1_pre_out", key_out, 32'h0);
      send_bit(1'b0);
      chk("t1_out", key_out, 32'hA5A50F0F);
      chk("t1_loaded", key_loaded, 1'b1);
      chk("t1_err", key_err, 1'b0);
      chk("t1_ready", key_ready, 1'b0);
      send_bit(1'b1);
      chk("t1_locked_hold", key_out, 32'hA5A50F0F);

      // 2: clear, then bad parity
      pulse_clear();
      chk("t2_clr_out", key_out, 32'h0);
      chk("t2_clr_loaded", key_loaded, 1'b0);
      chk("t2_clr_ready", key_ready, 1'b1);
      send_key(32'hA5A50F0F, 1'b1);
      chk("t2_out", key_out, 32'h0);
      chk("t2_loaded", key_loaded, 1'b0);
      chk("t2_err", key_err, 1'b1);
      chk("t2_ready", key_ready, 1'b1);
      chk("t2_dead", key_dead, 1'b0);

      // 3: lockout after four consecutive failures
      do_reset();
      for (int i = 0; i < 3; i++) send_key(32'hA5A50F0F, 1'b1);
      chk("t3_3bad_dead", key_dead, 1'b0);
      send_key(32'hA5A50F0F, 1'b1);
      chk("t3_dead", key_dead, 1'b1);
      chk("t3_ready", key_ready, 1'b0);
      chk("t3_out", key_out, 32'h0);
      pulse_clear();
      chk("t3_clr_dead", key_dead, 1'b1);
      chk("t3_clr_ready", key_ready, 1'b0);
      do_reset();
      chk("t3_rst_dead", key_dead, 1'b0);
      chk("t3_rst_err", key_err, 1'b0);
      for (int i = 0; i < 3; i++) send_key(32'hA5A50F0F, 1'b1);
      chk("t3_failcnt_cleared", key_dead, 1'b0);

      // 4: clear mid-load with a same-cycle valid bit
      do_reset();
      send_bits(32'hFFFFFFFF, 10, 1'b0);
      @(negedge clk);
      key_clear = 1'b1;
      key_valid = 1'b1;
      key_bit   = 1'b1;
      @(posedge clk); #1;
      key_clear = 1'b0;
      key_valid = 1'b0;
      key_bit   = 1'b0;
      send_key(32'h12345678, 1'b1);
      chk("t4_out", key_out, 32'h12345678);
      chk("t4_loaded", key_loaded, 1'b1);
      chk("t4_err", key_err, 1'b0);

      // 5: recovery resets the failure count
      do_reset();
      for (int i = 0; i < 3; i++) send_key(32'hA5A50F0F, 1'b1);
      send_key(32'hFFFFFFFF, 1'b0);
      chk("t5_out", key_out, 32'hFFFFFFFF);
      chk("t5_loaded", key_loaded, 1'b1);
      chk("t5_err", key_err, 1'b0);
      pulse_clear();
      for (int i = 0; i < 3; i++) send_key(32'hA5A50F0F, 1'b1);
      chk("t5_not_dead", key_dead, 1'b0);
      chk("t5_err_after", key_err, 1'b1);
      send_key(32'hA5A50F0F, 1'b1);
      chk("t5_fourth_dead", key_dead, 1'b1);

      // 6: stalls, then reset in the middle of a load
      do_reset();
      send_bits(32'hA5A50F0F, 32, 1'b1);
      send_bit(1'b0);
      chk("t6_gap_out", key_out, 32'hA5A50F0F);
      chk("t6_gap_loaded", key_loaded, 1'b1);
      pulse_clear();
      send_key(32'h12345678, 1'b0);
      chk("t6_bad_err", key_err, 1'b1);
      send_bits(32'h0000FFFF, 20, 1'b1);
      @(negedge clk);
      rst       = 1'b1;
      key_valid = 1'b1;
      key_bit   = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      key_valid = 1'b0;
      key_bit   = 1'b0;
      chk("t6_rst_out", key_out, 32'h0);
      chk("t6_rst_loaded", key_loaded, 1'b0);
      chk("t6_rst_err", key_err, 1'b0);
      chk("t6_rst_dead", key_dead, 1'b0);
      chk("t6_rst_ready", key_ready, 1'b1);
      send_key(32'h12345678, 1'b1);
      chk("t6_reload_out", key_out, 32'h12345678);
      chk("t6_reload_loaded", key_loaded, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
